// File: rtl/teatris_carregador_mapa_pkg.sv
// Shared definitions for the map loader.
// Holds the FSM states and the geometry of the map pattern ROM.
package teatris_pkg;

    localparam int NUM_LINHAS       = 8;
    localparam int LARGURA_LINHA    = 8;
    localparam int LARGURA_ENDERECO = 4;
    localparam int LARGURA_BLOCOS   = 7;

    typedef enum logic [2:0] {
        OCIOSO,
        ENDERECA,
        AGUARDA,
        ESCREVE,
        FIM
    } estado_t;

endpackage

// File: rtl/teatris_carregador_mapa_if.sv
// Bundle of the signals that connect the map loader to the game FSM, the pattern ROM and the playfield.
// The loader uses the master side; the surrounding logic uses the slave side.
interface teatris_carregador_mapa_if;
    import teatris_pkg::*;

    logic                                iniciar;
    logic [1:0]                          nivel;
    logic [1:0]                          sorteio;
    logic [LARGURA_ENDERECO-1:0]         endereco;
    logic [NUM_LINHAS*LARGURA_LINHA-1:0] padrao;
    logic                                linha_valida;
    logic [$clog2(NUM_LINHAS)-1:0]       linha_idx;
    logic [LARGURA_LINHA-1:0]            linha_dado;
    logic                                linha_aceita;
    logic                                ocupado;
    logic                                concluido;
    logic [LARGURA_BLOCOS-1:0]           blocos;

    modport master (
        input  iniciar, nivel, sorteio, padrao, linha_aceita,
        output endereco, linha_valida, linha_idx, linha_dado, ocupado, concluido, blocos
    );

    modport slave (
        output iniciar, nivel, sorteio, padrao, linha_aceita,
        input  endereco, linha_valida, linha_idx, linha_dado, ocupado, concluido, blocos
    );

endinterface

// File: rtl/teatris_carregador_mapa_contador_bits.sv
// Combinational popcount of one map row.
// Returns the number of obstacle cells in that row.
module teatris_contador_bits (
    input  logic [7:0] i_dado,
    output logic [3:0] o_contagem
);

    always_comb begin
        o_contagem = '0;
        for (int i = 0; i < 8; i++) begin
            o_contagem = o_contagem + {3'b000, i_dado[i]};
        end
    end

endmodule

// File: rtl/teatris_carregador_mapa.sv
// Map loader: addresses the pattern ROM, waits out its latency, then streams the pattern row by row
// into the playfield while accumulating the obstacle count.
module teatris_carregador_mapa #(
    parameter int NUM_LINHAS    = 8,
    parameter int LARGURA_LINHA = 8,
    parameter int LATENCIA_ROM  = 1
) (
    input logic                       clock,
    input logic                       reset,
    teatris_carregador_mapa_if.master bus
);
    import teatris_pkg::*;

    localparam int LARGURA_PADRAO = NUM_LINHAS * LARGURA_LINHA;
    localparam int LARGURA_IDX    = $clog2(NUM_LINHAS);
    localparam int LARGURA_LAT    = (LATENCIA_ROM > 1) ? $clog2(LATENCIA_ROM) : 1;
    localparam logic [LARGURA_IDX-1:0] ULTIMA_LINHA  = LARGURA_IDX'(NUM_LINHAS - 1);
    localparam logic [LARGURA_LAT-1:0] ULTIMA_ESPERA = LARGURA_LAT'(LATENCIA_ROM - 1);

    estado_t                     r_estado;
    estado_t                     w_proximo;
    logic [LARGURA_ENDERECO-1:0] r_endereco;
    logic [LARGURA_PADRAO-1:0]   r_padrao;
    logic [LARGURA_IDX-1:0]      r_linhaIdx;
    logic [LARGURA_LAT-1:0]      r_contLat;
    logic [LARGURA_BLOCOS-1:0]   r_blocos;
    logic [3:0]                  w_contagem;
    logic [LARGURA_LINHA-1:0]    w_linhaDado;
    logic                        w_aceita;
    logic                        w_ultima;

    assign w_linhaDado = r_padrao[LARGURA_PADRAO-1 -: LARGURA_LINHA];
    assign w_aceita    = (r_estado == ESCREVE) && bus.linha_aceita;
    assign w_ultima    = (r_linhaIdx == ULTIMA_LINHA);

    teatris_contador_bits u_contador (
        .i_dado     (w_linhaDado),
        .o_contagem (w_contagem)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo        = r_estado;
        bus.linha_valida = 1'b0;
        bus.ocupado      = 1'b0;
        bus.concluido    = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (bus.iniciar) w_proximo = ENDERECA;
            end
            ENDERECA: begin
                bus.ocupado = 1'b1;
                if (r_contLat == ULTIMA_ESPERA) w_proximo = AGUARDA;
            end
            AGUARDA: begin
                bus.ocupado = 1'b1;
                w_proximo   = ESCREVE;
            end
            ESCREVE: begin
                bus.ocupado      = 1'b1;
                bus.linha_valida = 1'b1;
                if (w_aceita && w_ultima) w_proximo = FIM;
            end
            FIM: begin
                bus.concluido = 1'b1;
                w_proximo     = OCIOSO;
            end
            default: w_proximo = OCIOSO;
        endcase
    end

    // The last row is never shifted out, so linha_dado keeps showing it after the load.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_endereco <= '0;
            r_padrao   <= '0;
            r_linhaIdx <= '0;
            r_contLat  <= '0;
            r_blocos   <= '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (bus.iniciar) begin
                        r_endereco <= {bus.nivel, bus.sorteio};
                        r_blocos   <= '0;
                        r_contLat  <= '0;
                    end
                end
                ENDERECA: begin
                    r_contLat <= r_contLat + 1'b1;
                end
                AGUARDA: begin
                    r_padrao   <= bus.padrao;
                    r_linhaIdx <= '0;
                end
                ESCREVE: begin
                    if (w_aceita) begin
                        r_blocos <= r_blocos + LARGURA_BLOCOS'(w_contagem);
                        if (!w_ultima) begin
                            r_padrao   <= r_padrao << LARGURA_LINHA;
                            r_linhaIdx <= r_linhaIdx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.endereco   = r_endereco;
    assign bus.linha_idx  = r_linhaIdx;
    assign bus.linha_dado = w_linhaDado;
    assign bus.blocos     = r_blocos;

endmodule

// File: tb/tb_teatris_carregador_mapa.sv
// Directed bench for the map loader with a registered ROM model in front of it.
// Covers basic load, backpressure, ignored starts, reset mid-load, extreme patterns and an address sweep.
module tb_teatris_carregador_mapa;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    logic [63:0] rom [16];

    teatris_carregador_mapa_if bus ();

    teatris_carregador_mapa #(
        .NUM_LINHAS    (8),
        .LARGURA_LINHA (8),
        .LATENCIA_ROM  (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered ROM: data follows the address one clock later.
    always @(posedge clock) bus.padrao <= rom[bus.endereco];

    task automatic checkOutput(input string tag, input logic [63:0] observado, input logic [63:0] esperado);
        checks++;
        if (observado !== esperado) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observado, esperado, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] n, input logic [1:0] s, input int stallRow,
                                 input int stallLen, input bit pulsoIgnorado);
        logic [63:0] palavra;
        logic [3:0]  endEsperado;
        int linha;
        int stalls;
        int concCiclo;
        int nConc;
        endEsperado = {n, s};
        palavra     = rom[endEsperado];
        linha       = 0;
        stalls      = 0;
        concCiclo   = -1;
        nConc       = 0;
        @(negedge clock);
        bus.iniciar = 1'b1;
        bus.nivel   = n;
        bus.sorteio = s;
        @(posedge clock);
        #1;
        bus.iniciar = 1'b0;
        bus.nivel   = ~n;
        bus.sorteio = ~s;
        for (int c = 1; c <= 40 && concCiclo < 0; c++) begin
            @(negedge clock);
            if (c == 1) begin
                checkOutput("endereco_T1", bus.endereco, endEsperado);
                checkOutput("ocupado_T1", bus.ocupado, 1);
                checkOutput("valida_T1", bus.linha_valida, 0);
            end
            if (pulsoIgnorado && c == 5) begin
                bus.iniciar = 1'b1;
                bus.nivel   = 2'd3;
            end
            if (pulsoIgnorado && c == 6) bus.iniciar = 1'b0;
            if (bus.linha_valida) begin
                checkOutput("linha_idx", bus.linha_idx, linha[2:0]);
                checkOutput("linha_dado", bus.linha_dado, palavra[63 - 8 * linha -: 8]);
                if (linha == stallRow && stalls < stallLen) begin
                    bus.linha_aceita = 1'b0;
                    stalls++;
                end else begin
                    bus.linha_aceita = 1'b1;
                    linha++;
                end
            end else begin
                bus.linha_aceita = 1'b1;
            end
            if (bus.concluido) begin
                nConc++;
                concCiclo = c;
                checkOutput("ocupado_fim", bus.ocupado, 0);
                if (pulsoIgnorado) bus.iniciar = 1'b1;
            end
        end
        checkOutput("concluido_ciclo", concCiclo, 11 + stallLen);
        checkOutput("linhas_escritas", linha, 8);
        checkOutput("blocos", bus.blocos, $countones(palavra));
        @(negedge clock);
        bus.iniciar = 1'b0;
        checkOutput("concluido_pulso", bus.concluido, 0);
        checkOutput("ocupado_apos", bus.ocupado, 0);
        checkOutput("valida_apos", bus.linha_valida, 0);
        checkOutput("endereco_mantido", bus.endereco, endEsperado);
        checkOutput("dado_mantido", bus.linha_dado, palavra[7:0]);
        @(negedge clock);
        checkOutput("sem_nova_carga", bus.ocupado, 0);
        checkOutput("blocos_mantido", bus.blocos, $countones(palavra));
        if (pulsoIgnorado) checkOutput("um_concluido", nConc, 1);
    endtask

    task automatic resetMeioCarga();
        bit achou;
        achou = 1'b0;
        @(negedge clock);
        bus.iniciar = 1'b1;
        bus.nivel   = 2'd2;
        bus.sorteio = 2'd3;
        @(posedge clock);
        #1;
        bus.iniciar = 1'b0;
        for (int c = 0; c < 20 && !achou; c++) begin
            @(negedge clock);
            bus.linha_aceita = 1'b1;
            if (bus.linha_valida && bus.linha_idx == 3'd4) achou = 1'b1;
        end
        checkOutput("reset_linha4_alcancada", achou, 1);
        reset       = 1'b1;
        bus.iniciar = 1'b1;
        @(negedge clock);
        checkOutput("reset_valida", bus.linha_valida, 0);
        checkOutput("reset_ocupado", bus.ocupado, 0);
        checkOutput("reset_concluido", bus.concluido, 0);
        checkOutput("reset_blocos", bus.blocos, 0);
        checkOutput("reset_endereco", bus.endereco, 0);
        reset       = 1'b0;
        bus.iniciar = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checkOutput("reset_sem_fila", bus.ocupado, 0);
            checkOutput("reset_sem_concluido", bus.concluido, 0);
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        bus.iniciar      = 1'b0;
        bus.nivel        = 2'd0;
        bus.sorteio      = 2'd0;
        bus.linha_aceita = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rom[i] = {8{8'(i * 17 + 3)}} ^ 64'h0F1E_2D3C_4B5A_6978;
        end
        rom[0]  = 64'h0;
        rom[1]  = {48'b0, 16'b0110000000110000};
        rom[15] = {64{1'b1}};

        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_endereco", bus.endereco, 0);
        checkOutput("rst_valida", bus.linha_valida, 0);
        checkOutput("rst_idx", bus.linha_idx, 0);
        checkOutput("rst_dado", bus.linha_dado, 0);
        checkOutput("rst_ocupado", bus.ocupado, 0);
        checkOutput("rst_concluido", bus.concluido, 0);
        checkOutput("rst_blocos", bus.blocos, 0);
        reset = 1'b0;

        $display("[TB] basic load");
        applyStimulus(2'd0, 2'd1, -1, 0, 1'b0);
        checkOutput("basic_blocos_4", bus.blocos, 4);

        $display("[TB] backpressure on row 2");
        applyStimulus(2'd0, 2'd1, 2, 3, 1'b0);

        $display("[TB] ignored start during load and in FIM");
        applyStimulus(2'd1, 2'd2, -1, 0, 1'b1);

        $display("[TB] reset mid-load");
        resetMeioCarga();
        applyStimulus(2'd2, 2'd3, -1, 0, 1'b0);

        $display("[TB] extremes");
        applyStimulus(2'd3, 2'd3, -1, 0, 1'b0);
        checkOutput("blocos_64", bus.blocos, 64);
        applyStimulus(2'd0, 2'd0, -1, 0, 1'b0);
        checkOutput("blocos_0", bus.blocos, 0);

        $display("[TB] address sweep");
        for (int a = 0; a < 16; a++) begin
            logic [3:0] ad;
            ad = 4'(a);
            applyStimulus(ad[3:2], ad[1:0], (a % 8), (a % 3), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
